// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the fp_mac dot-product sequencer.
// State encoding plus fp16/fp32 bit patterns used around the datapath.
package fp_mac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_LD,
      ST_MAC,
      ST_DONE
   } seq_state_t;

   localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
   localparam logic [15:0] FP16_ONE  = 16'h3C00;
   localparam logic [15:0] FP16_TWO  = 16'h4000;

endpackage

// File: rtl/mac_wait_cnt.sv
// Loadable down-counter with zero flag; times the MAC hold window.
// Load takes priority over decrement; it saturates at zero and never backpressures.
module mac_wait_cnt #(
   parameter int W = 2
) (
   input  logic         CLK,
   input  logic         RESETn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/fp_mac_seq.sv
// Dot-product sequencer: reads len fp16 pairs, accumulates via fp_mac, pulses done with the fp32 sum.
// Latency len*(MAC_LAT+3)+1 cycles from start; a start while busy is dropped, with no backpressure.
module fp_mac_seq
   import fp_mac_pkg::*;
#(
   parameter int MAC_LAT = 2,
   parameter int ADDR_W  = 8,
   parameter int LEN_W   = 9
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [31:0]       acc_init,
   output logic              busy,
   output logic              done,
   output logic [31:0]       result,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_a_addr,
   output logic [ADDR_W-1:0] mem_b_addr,
   input  logic [15:0]       mem_a_data,
   input  logic [15:0]       mem_b_data,
   output logic [15:0]       mac_a,
   output logic [15:0]       mac_b,
   output logic [31:0]       mac_c,
   input  logic [31:0]       mac_y
);

   localparam int CNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

   seq_state_t        state;
   logic [LEN_W-1:0]  remaining;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [31:0]       acc;
   logic              wait_zero;

   mac_wait_cnt #(
      .W(CNT_W)
   ) u_wait (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .load    (state == ST_LD),
      .load_val(CNT_W'(MAC_LAT)),
      .en      (state == ST_MAC),
      .zero    (wait_zero)
   );

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state     <= ST_IDLE;
         remaining <= '0;
         addr_a    <= '0;
         addr_b    <= '0;
         acc       <= FP32_ZERO;
         mac_a     <= '0;
         mac_b     <= '0;
         result    <= FP32_ZERO;
         done      <= 1'b0;
         busy      <= 1'b0;
         mem_rd    <= 1'b0;
      end else begin
         done   <= 1'b0;
         mem_rd <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  remaining <= len;
                  addr_a    <= base_a;
                  addr_b    <= base_b;
                  acc       <= acc_init;
                  busy      <= 1'b1;
                  if (len == '0) begin
                     state  <= ST_DONE;
                     done   <= 1'b1;
                     result <= acc_init;
                  end else begin
                     state  <= ST_RD;
                     mem_rd <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               state <= ST_LD;
            end
            ST_LD: begin
               mac_a <= mem_a_data;
               mac_b <= mem_b_data;
               state <= ST_MAC;
            end
            ST_MAC: begin
               // mac_y is only meaningful once the wait window has fully elapsed
               if (wait_zero) begin
                  acc       <= mac_y;
                  remaining <= remaining - LEN_W'(1);
                  addr_a    <= addr_a + ADDR_W'(1);
                  addr_b    <= addr_b + ADDR_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state  <= ST_DONE;
                     done   <= 1'b1;
                     result <= mac_y;
                  end else begin
                     state  <= ST_RD;
                     mem_rd <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_a_addr = addr_a;
   assign mem_b_addr = addr_b;
   assign mac_c      = acc;

endmodule

// File: tb/tb_fp_mac_seq.sv
// Bench for fp_mac_seq with a behavioural fp_mac pipeline and operand memories.
// Expected sums and done cycles are queued at start and checked when done pulses.
module tb_fp_mac_seq;
   import fp_mac_pkg::*;

   localparam int MAC_LAT = 2;
   localparam int ADDR_W  = 8;
   localparam int LEN_W   = 9;
   localparam int P       = MAC_LAT + 3;

   logic              CLK = 1'b0;
   logic              RESETn;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic [ADDR_W-1:0] base_a;
   logic [ADDR_W-1:0] base_b;
   logic [31:0]       acc_init;
   logic              busy;
   logic              done;
   logic [31:0]       result;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_a_addr;
   logic [ADDR_W-1:0] mem_b_addr;
   logic [15:0]       mem_a_data;
   logic [15:0]       mem_b_data;
   logic [15:0]       mac_a;
   logic [15:0]       mac_b;
   logic [31:0]       mac_c;
   logic [31:0]       mac_y;

   fp_mac_seq #(
      .MAC_LAT(MAC_LAT),
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) dut (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .start     (start),
      .len       (len),
      .base_a    (base_a),
      .base_b    (base_b),
      .acc_init  (acc_init),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .mem_rd    (mem_rd),
      .mem_a_addr(mem_a_addr),
      .mem_b_addr(mem_b_addr),
      .mem_a_data(mem_a_data),
      .mem_b_data(mem_b_data),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_c     (mac_c),
      .mac_y     (mac_y)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int rd_count = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // fp helpers: exact for the small operand values used here
   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      int  e = int'(h[14:10]);
      real m = real'(int'(h[9:0]));
      real v;
      if (e == 0) v = m * pow2(-24);
      else        v = (1.0 + m / 1024.0) * pow2(e - 15);
      return h[15] ? -v : v;
   endfunction

   function automatic real f2r(input logic [31:0] f);
      int  e = int'(f[30:23]);
      real m = real'(int'(f[22:0]));
      real v;
      if (e == 0) v = m * pow2(-149);
      else        v = (1.0 + m / 8388608.0) * pow2(e - 127);
      return f[31] ? -v : v;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      int          ee;
      if (r == 0.0) return 32'h0;
      b  = $realtobits(r);
      ee = int'(b[62:52]) - 1023 + 127;
      return {b[63], ee[7:0], b[51:29]};
   endfunction

   // Behavioural fp_mac: Y = A*B + C, MAC_LAT cycles after inputs
   logic [31:0] y_comb;
   logic [31:0] y_pipe [MAC_LAT];
   always_comb y_comb = r2f(h2r(mac_a) * h2r(mac_b) + f2r(mac_c));
   always @(posedge CLK) begin
      y_pipe[0] <= y_comb;
      for (int i = 1; i < MAC_LAT; i++) y_pipe[i] <= y_pipe[i-1];
   end
   assign mac_y = y_pipe[MAC_LAT-1];

   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   always @(posedge CLK) begin
      if (mem_rd) begin
         mem_a_data <= mem_a[mem_a_addr];
         mem_b_data <= mem_b[mem_b_addr];
      end
   end

   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;
   exp_t sb_q [$];
   logic [ADDR_W-1:0] rd_log [$];

   function automatic logic [31:0] model(input int n, input logic [7:0] ba, input logic [7:0] bb,
                                         input logic [31:0] ai);
      real s = f2r(ai);
      logic [7:0] a_i;
      logic [7:0] b_i;
      for (int i = 0; i < n; i++) begin
         a_i = ba + 8'(i);
         b_i = bb + 8'(i);
         s = s + h2r(mem_a[a_i]) * h2r(mem_b[b_i]);
      end
      return r2f(s);
   endfunction

   always @(negedge CLK) begin
      if (RESETn) begin
         if (mem_rd) begin
            rd_count++;
            rd_log.push_back(mem_a_addr);
         end
         if (done) begin
            if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("result", result, e.res);
               chk("done_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic issue(input int n, input logic [7:0] ba, input logic [7:0] bb, input logic [31:0] ai);
      exp_t e;
      @(negedge CLK);
      len      = LEN_W'(n);
      base_a   = ba;
      base_b   = bb;
      acc_init = ai;
      start    = 1'b1;
      e.res    = model(n, ba, bb, ai);
      e.cyc    = cyc + n * P + 1;
      sb_q.push_back(e);
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      chk("done_seen", ok, 1);
   endtask

   logic [15:0] vals [6];
   logic [7:0]  wrap_exp [4];
   int          rd0;

   initial begin
      vals = '{16'h3C00, 16'h4000, 16'h3800, 16'h4200, 16'hBC00, 16'hC000};
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = vals[$urandom_range(0, 5)];
         mem_b[i] = vals[$urandom_range(0, 5)];
      end
      mem_a[0] = FP16_ONE;
      mem_a[1] = FP16_TWO;
      mem_b[0] = FP16_TWO;
      mem_b[1] = FP16_TWO;

      RESETn = 1'b0; start = 1'b0; len = '0; base_a = '0; base_b = '0; acc_init = '0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mac_c", mac_c, 0);
      chk("rst_mac_a", mac_a, 0);
      chk("rst_addr_a", mem_a_addr, 0);
      RESETn = 1'b1;

      // two elements: 1*2 + 2*2 = 6.0
      rd0 = rd_count;
      issue(2, 8'h00, 8'h00, 32'h0);
      chk("busy_running", busy, 1);
      wait_done();
      chk("two_elem_result", result, 32'h40C00000);
      chk("two_elem_reads", rd_count - rd0, 2);
      repeat (2) @(negedge CLK);
      chk("result_hold", result, 32'h40C00000);
      chk("idle_busy", busy, 0);

      // zero length
      rd0 = rd_count;
      issue(0, 8'h10, 8'h20, 32'h3F800000);
      wait_done();
      chk("zero_len_result", result, 32'h3F800000);
      chk("zero_len_reads", rd_count - rd0, 0);

      // address wrap
      @(negedge CLK);
      rd_log.delete();
      issue(4, 8'hFE, 8'h40, 32'h40000000);
      wait_done();
      wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      chk("wrap_nreads", rd_log.size(), 4);
      for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("wrap_addr", rd_log[i], wrap_exp[i]);

      // start while busy is dropped
      rd0 = rd_count;
      issue(3, 8'h30, 8'h50, 32'h3F800000);
      repeat (3) @(negedge CLK);
      len = LEN_W'(5); base_a = 8'h77; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      wait_done();
      chk("busy_start_reads", rd_count - rd0, 3);

      // reset during MAC of element 3
      @(negedge CLK);
      issue(4, 8'h60, 8'h70, 32'h3F800000);
      repeat (2 * P + 2) @(negedge CLK);
      RESETn = 1'b0;
      #1;
      void'(sb_q.pop_back());
      chk("abort_busy", busy, 0);
      chk("abort_mac_a", mac_a, 0);
      chk("abort_mac_c", mac_c, 0);
      chk("abort_result", result, 0);
      chk("abort_mem_rd", mem_rd, 0);
      @(negedge CLK);
      RESETn = 1'b1;
      repeat (30) @(negedge CLK);
      chk("abort_no_pending", sb_q.size(), 0);
      issue(5, 8'h60, 8'h70, 32'hBF800000);
      wait_done();

      // back-to-back, then start during DONE is ignored
      issue(3, 8'h05, 8'h09, 32'h40000000);
      wait_done();
      issue(2, 8'hA0, 8'hB0, 32'hC0400000);
      wait_done();
      issue(1, 8'h11, 8'h12, 32'h0);
      wait_done();
      len = LEN_W'(7); start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (3) @(negedge CLK);
      chk("done_start_ignored", busy, 0);
      chk("sb_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
